cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate cache controller between the CPU request port (start_to_cache/address/data/read_operation) and the shared memory bus. It accepts one CPU request at a time and asserts cache_busy while working. It resolves hits locally and sequences bus request/grant/transfer/ack for read fills and all writes. It also keeps saturating hit/miss counters for debug.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width (one word per line)
LINES, 8, number of lines, power of 2; IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start_to_cache  in  1  CPU request strobe, sampled only when cache_busy=0
address  in  ADDR_W  request address
data  in  DATA_W  write data
read_operation  in  1  1=read, 0=write
flush  in  1  invalidate all lines
cache_busy  out  1  controller not accepting requests
read_data  out  DATA_W  read result
read_valid  out  1  one-cycle pulse, read_data valid
bus_busy  out  1  controller owns or requests the bus
bus_req  out  1  bus request to arbiter
bus_grant  in  1  arbiter grant
bus_valid  out  1  transfer qualifier
bus_we  out  1  1=write transfer
bus_addr  out  ADDR_W  transfer address
bus_wdata  out  DATA_W  transfer write data
bus_rdata  in  DATA_W  read return data
bus_ack  in  1  transfer complete, one cycle
hit_count  out  8  saturating at 8'hFF
miss_count  out  8  saturating at 8'hFF

Behaviour:
- Reset (async, rst=1): state IDLE; all valid bits 0; every output 0 (cache_busy, read_valid, bus_*, counters, read_data). Reset mid-transfer abandons it; bus_req/bus_valid drop immediately.
- Index=address[IDX_W-1:0], tag=address[ADDR_W-1:IDX_W].
- FSM states: IDLE, FLUSH, LOOKUP, BUS_REQ, BUS_XFER.
- IDLE: flush=1 -> FLUSH; flush has priority over start_to_cache in the same cycle, and that request is dropped. Otherwise start_to_cache=1 -> latch address/data/op and go to LOOKUP. cache_busy=0 only in IDLE.
- FLUSH: clear all valid bits in one cycle, then IDLE. flush asserted outside IDLE is ignored.
- LOOKUP (1 cycle):
  - Read hit: hit_count++; read_data<=line data; read_valid=1 on the edge leaving LOOKUP; go to IDLE. Hit latency: read_valid is high in the 2nd cycle after the request is sampled.
  - Read miss: miss_count++; go to BUS_REQ.
  - Write hit: update line data; hit_count++; go to BUS_REQ.
  - Write miss: miss_count++; no allocation; go to BUS_REQ.
- BUS_REQ: bus_req=1 and bus_busy=1 until bus_grant=1 is sampled. Then go to BUS_XFER. Waiting is unbounded.
- BUS_XFER:
  - bus_req=1, bus_valid=1, bus_addr=latched address, bus_we=!op, bus_wdata=latched data (0 for reads).
  - All are held stable until bus_ack. A grant drop before ack is ignored; the transfer holds.
  - On bus_ack, read: write line {valid=1, tag, bus_rdata}, evicting the previous occupant. read_data<=bus_rdata and read_valid pulses on the next cycle.
  - On bus_ack, write: complete with no read_valid.
  - Then IDLE; bus_req, bus_valid and bus_busy deassert on the same edge.
- bus_ack outside BUS_XFER is ignored.
- start_to_cache while cache_busy=1 is ignored; the CPU must retry.
- Counters saturate at 8'hFF and never wrap.

Decomposition:
- cache_ctrl_pkg holds the state enum (IDLE, FLUSH, LOOKUP, BUS_REQ, BUS_XFER) and default width constants.
- Sub-module cache_line_array holds valid/tag/data storage with one combinational read port (index), one synchronous write port, and a one-cycle flush clear. It is async-reset clearing valid bits only.

Test Plan:
- Read miss 0x2A, grant after 3 cycles, ack with bus_rdata=0x5C -> bus_addr=0x2A, bus_we=0, read_data=0x5C with read_valid pulse, miss_count=1.
- Repeat read 0x2A -> no bus_req, read_valid 2 cycles after request, read_data=0x5C, hit_count=1.
- Write 0x2A data 0x77 (hit) -> bus write 0x2A/0x77. Then read 0x2A hits with 0x77.
- Write miss 0x10 data 0x11, then read 0x10 -> write goes to bus, no allocation; the read misses and issues a bus read.
- Read 0x32 (index 2, tag 6) after 0x2A is cached -> miss, fill evicts 0x2A, and a following read of 0x2A misses.
- rst asserted during BUS_XFER, then flush with start_to_cache in the same cycle:
  - rst: outputs 0 at once.
  - flush: request dropped, all lines invalid, next read of 0x2A misses.
  - 256 hits keep hit_count=0xFF.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the direct-mapped write-through cache controller.
package cache_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LINES  = 8;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LOOKUP,
    BUS_REQ,
    BUS_XFER
  } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port, single-cycle flush.
module cache_line_array
  import cache_ctrl_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int IDX_W  = $clog2(DEF_LINES),
  parameter int TAG_W  = DEF_ADDR_W - $clog2(DEF_LINES),
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_bits;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // Only the valid bits are reset; tag/data contents are meaningless until a line is marked valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (flush_all) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_bits[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with bus request/grant/ack
// sequencing for read fills and all writes, plus saturating hit/miss debug counters.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES  = DEF_LINES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_to_cache,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              read_operation,
  input  logic              flush,
  output logic              cache_busy,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              bus_busy,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  state_t state, next_state;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_read;
  logic              accept;

  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              fill_done;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  // A flush in the same cycle as a request wins and the request is dropped.
  assign accept    = (state == IDLE) && !flush && start_to_cache;
  assign hit       = line_valid && (line_tag == req_addr[ADDR_W-1:IDX_W]);
  assign fill_done = (state == BUS_XFER) && bus_ack && req_read;
  assign wr_en     = ((state == LOOKUP) && !req_read && hit) || fill_done;
  assign wr_data   = (state == LOOKUP) ? req_data : bus_rdata;

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= address;
      req_data <= data;
      req_read <= read_operation;
    end
  end

  cache_line_array #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .flush_all (state == FLUSH),
    .rd_idx    (req_addr[IDX_W-1:0]),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (wr_en),
    .wr_idx    (req_addr[IDX_W-1:0]),
    .wr_tag    (req_addr[ADDR_W-1:IDX_W]),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bus outputs are decoded from state so an async reset drops them immediately.
  always_comb begin
    next_state = state;
    cache_busy = 1'b1;
    bus_req    = 1'b0;
    bus_busy   = 1'b0;
    bus_valid  = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    case (state)
      IDLE: begin
        cache_busy = 1'b0;
        if (flush) begin
          next_state = FLUSH;
        end else if (start_to_cache) begin
          next_state = LOOKUP;
        end
      end
      FLUSH: begin
        next_state = IDLE;
      end
      LOOKUP: begin
        next_state = (req_read && hit) ? IDLE : BUS_REQ;
      end
      BUS_REQ: begin
        bus_req  = 1'b1;
        bus_busy = 1'b1;
        if (bus_grant) begin
          next_state = BUS_XFER;
        end
      end
      BUS_XFER: begin
        bus_req   = 1'b1;
        bus_busy  = 1'b1;
        bus_valid = 1'b1;
        bus_we    = !req_read;
        bus_addr  = req_addr;
        bus_wdata = req_read ? '0 : req_data;
        if (bus_ack) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      hit_count  <= 8'h00;
      miss_count <= 8'h00;
    end else begin
      read_valid <= 1'b0;
      if (state == LOOKUP) begin
        if (hit) begin
          hit_count <= sat_inc(hit_count);
          if (req_read) begin
            read_data  <= line_data;
            read_valid <= 1'b1;
          end
        end else begin
          miss_count <= sat_inc(miss_count);
        end
      end
      if (fill_done) begin
        read_data  <= bus_rdata;
        read_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed CPU requests, a scripted bus responder, and a monitor
// that pops expected read results and bus transfers whenever the DUT presents them.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_start;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_read;
  logic       flush;
  logic       cache_busy;
  logic [7:0] read_data;
  logic       read_valid;
  logic       bus_busy;
  logic       bus_req;
  logic       bus_grant;
  logic       bus_valid;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } bus_exp_t;

  logic [7:0] rd_q [$];
  bus_exp_t   bus_q [$];
  bus_exp_t   bus_cur;
  logic       bus_prev = 1'b0;

  int compared   = 0;
  int mismatched = 0;
  int exp_hits   = 0;
  int exp_miss   = 0;

  cache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start_to_cache (cpu_start),
    .address        (cpu_addr),
    .data           (cpu_data),
    .read_operation (cpu_read),
    .flush          (flush),
    .cache_busy     (cache_busy),
    .read_data      (read_data),
    .read_valid     (read_valid),
    .bus_busy       (bus_busy),
    .bus_req        (bus_req),
    .bus_grant      (bus_grant),
    .bus_valid      (bus_valid),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every read_valid pulse and every bus_valid cycle against the queues.
  always @(negedge clk) begin
    if (read_valid) begin
      if (rd_q.size() == 0) begin
        check("read_unexpected", 32'(read_valid), 32'(1'b0));
      end else begin
        check("read_data", 32'(read_data), 32'(rd_q.pop_front()));
      end
    end
    if (bus_valid && !bus_prev) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 32'(bus_valid), 32'(1'b0));
        bus_cur = '{bus_addr, bus_we, bus_wdata};
      end else begin
        bus_cur = bus_q.pop_front();
      end
    end
    if (bus_valid) begin
      check("bus_addr", 32'(bus_addr), 32'(bus_cur.addr));
      check("bus_we", 32'(bus_we), 32'(bus_cur.we));
      check("bus_wdata", 32'(bus_wdata), 32'(bus_cur.wdata));
    end
    bus_prev = bus_valid;
  end

  task automatic wait_idle();
    int n = 0;
    while (cache_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(cache_busy), 32'(1'b0));
  endtask

  task automatic cpu_req(input logic [7:0] a, input logic [7:0] d, input logic rd);
    wait_idle();
    @(negedge clk);
    cpu_addr  = a;
    cpu_data  = d;
    cpu_read  = rd;
    cpu_start = 1'b1;
    @(posedge clk);
    #1;
    cpu_start = 1'b0;
  endtask

  task automatic serve_bus(input int delay, input logic [7:0] rdata);
    int n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bus_req_seen", 32'(bus_req), 32'(1'b1));
    repeat (delay) @(negedge clk);
    check("bus_valid_pre_grant", 32'(bus_valid), 32'(1'b0));
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    check("bus_valid_granted", 32'(bus_valid), 32'(1'b1));
    repeat (2) @(negedge clk);
    check("bus_hold_after_grant_drop", 32'(bus_valid), 32'(1'b1));
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    check("bus_release", 32'({bus_req, bus_valid, bus_busy}), 32'(3'b000));
  endtask

  task automatic check_counts();
    check("hit_count", 32'(hit_count), 32'(exp_hits));
    check("miss_count", 32'(miss_count), 32'(exp_miss));
  endtask

  task automatic do_read(input logic [7:0] a, input logic is_hit, input logic [7:0] exp);
    rd_q.push_back(exp);
    if (is_hit) begin
      cpu_req(a, 8'h00, 1'b1);
      check("hit_lookup_rv", 32'(read_valid), 32'(1'b0));
      @(posedge clk);
      #1;
      check("hit_latency_rv", 32'(read_valid), 32'(1'b1));
      if (exp_hits < 255) exp_hits++;
    end else begin
      bus_q.push_back('{a, 1'b0, 8'h00});
      cpu_req(a, 8'h00, 1'b1);
      serve_bus(3, exp);
      if (exp_miss < 255) exp_miss++;
    end
    wait_idle();
    repeat (2) @(negedge clk);
    check_counts();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic is_hit);
    bus_q.push_back('{a, 1'b1, d});
    cpu_req(a, d, 1'b0);
    serve_bus(1, 8'hEE);
    if (is_hit) exp_hits++;
    else exp_miss++;
    wait_idle();
    repeat (2) @(negedge clk);
    check_counts();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cpu_start = 1'b0;
    cpu_addr  = 8'h00;
    cpu_data  = 8'h00;
    cpu_read  = 1'b0;
    flush     = 1'b0;
    bus_grant = 1'b0;
    bus_rdata = 8'h00;
    bus_ack   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({cache_busy, read_valid, bus_req, bus_valid, bus_busy, bus_we}), 32'(6'b0));
    check("reset_read_data", 32'(read_data), 32'(8'h00));
    check_counts();
    rst = 1'b0;

    // Fill, hit, write-through hit, write miss without allocation, eviction.
    do_read(8'h2A, 1'b0, 8'h5C);
    do_read(8'h2A, 1'b1, 8'h5C);
    do_write(8'h2A, 8'h77, 1'b1);
    do_read(8'h2A, 1'b1, 8'h77);
    do_write(8'h10, 8'h11, 1'b0);
    do_read(8'h10, 1'b0, 8'h11);
    do_read(8'h32, 1'b0, 8'hA3);
    do_read(8'h2A, 1'b0, 8'h77);

    // Reset in the middle of a bus read transfer.
    bus_q.push_back('{8'h55, 1'b0, 8'h00});
    cpu_req(8'h55, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    check("xfer_before_reset", 32'(bus_valid), 32'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_bus_drop", 32'({bus_req, bus_valid, bus_busy, cache_busy, read_valid}), 32'(5'b0));
    check("rst_bus_addr", 32'(bus_addr), 32'(8'h00));
    check("rst_read_data", 32'(read_data), 32'(8'h00));
    exp_hits = 0;
    exp_miss = 0;
    check_counts();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Flush wins over a same-cycle request; the request is dropped.
    do_read(8'h2A, 1'b0, 8'h5C);
    do_read(8'h2A, 1'b1, 8'h5C);
    wait_idle();
    @(negedge clk);
    flush     = 1'b1;
    cpu_start = 1'b1;
    cpu_addr  = 8'h2A;
    cpu_read  = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    cpu_start = 1'b0;
    check("flush_busy", 32'(cache_busy), 32'(1'b1));
    @(posedge clk);
    #1;
    check("flush_back_idle", 32'(cache_busy), 32'(1'b0));
    repeat (3) @(negedge clk);
    check_counts();
    do_read(8'h2A, 1'b0, 8'h5C);

    // Hit counter saturation.
    for (int i = 0; i < 256; i++) begin
      do_read(8'h2A, 1'b1, 8'h5C);
    end
    check("hit_saturated", 32'(hit_count), 32'(8'hFF));

    repeat (3) @(negedge clk);
    check("rd_q_drained", 32'(rd_q.size()), 32'(0));
    check("bus_q_drained", 32'(bus_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
